eth_stats_collector_mc: RTL and testbench

ETH_STATS_COLLECTOR_MC -- requirements
Module: eth_stats_collector_mc

---
 rtl/eth_stats_pkg.sv | 18 +
 rtl/eth_stats_port_counter.sv | 68 ++++++
 rtl/eth_stats_collector_mc.sv | 215 +++++++++++++++++++++
 tb/tb_eth_stats_collector_mc.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_stats_pkg.sv
// Shared definitions for the Ethernet statistics collector: the log FSM
// state type and constants, the log word width and the packet layout.
package eth_stats_pkg;

  localparam int LOG_WORD_W     = 64;
  localparam int WORDS_PER_PORT = 2;

  typedef logic [0:0] log_state_t;

  localparam log_state_t ST_IDLE = 1'b0;
  localparam log_state_t ST_SEND = 1'b1;

  // One timestamp word followed by the per-port words
  function automatic int words_per_packet(input int num_ports);
    return 1 + WORDS_PER_PORT * num_ports;
  endfunction

endpackage

// File: rtl/eth_stats_port_counter.sv
// Byte, frame and bad-frame counters for one monitored stream.
// Counters wrap by default; with ETH_STATS_SATURATE_EN defined they stick
// at their all-ones value instead.
module eth_stats_port_counter
  import eth_stats_pkg::*;
#(
  parameter int C_FRAME_CNT_WIDTH = 32,
  parameter int C_BYTE_CNT_WIDTH  = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear_i,
  input  logic                         beat_i,
  input  logic                         last_i,
  input  logic                         user_i,
  output logic [C_BYTE_CNT_WIDTH-1:0]  bytes_o,
  output logic [C_FRAME_CNT_WIDTH-1:0] frames_o,
  output logic [C_FRAME_CNT_WIDTH-1:0] bad_o
);

`ifdef ETH_STATS_SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  logic [C_BYTE_CNT_WIDTH-1:0]  bytes_q,  bytes_d;
  logic [C_FRAME_CNT_WIDTH-1:0] frames_q, frames_d;
  logic [C_FRAME_CNT_WIDTH-1:0] bad_q,    bad_d;

  // Next counter values: clear beats any same-cycle beat
  always_comb begin
    bytes_d  = bytes_q;
    frames_d = frames_q;
    bad_d    = bad_q;
    if (clear_i) begin
      bytes_d  = '0;
      frames_d = '0;
      bad_d    = '0;
    end else if (beat_i) begin
      bytes_d = (SATURATE && (&bytes_q)) ? bytes_q : bytes_q + 1'b1;
      if (last_i) begin
        frames_d = (SATURATE && (&frames_q)) ? frames_q : frames_q + 1'b1;
        if (user_i) begin
          bad_d = (SATURATE && (&bad_q)) ? bad_q : bad_q + 1'b1;
        end
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bytes_q  <= '0;
      frames_q <= '0;
      bad_q    <= '0;
    end else begin
      bytes_q  <= bytes_d;
      frames_q <= frames_d;
      bad_q    <= bad_d;
    end
  end

  assign bytes_o  = bytes_q;
  assign frames_o = frames_q;
  assign bad_o    = bad_q;

endmodule

// File: rtl/eth_stats_collector_mc.sv
// Multi-port Ethernet statistics collector. Counts beats, frames and bad
// frames per monitored stream and, on a manual or periodic request,
// snapshots all counters plus a timestamp and streams them out as a
// packet of 64-bit words. Requests that arrive while a packet is being
// sent are dropped and flagged.
// Optional build macro: ETH_STATS_SATURATE_EN (saturating counters).
module eth_stats_collector_mc
  import eth_stats_pkg::*;
#(
  parameter int C_NUM_PORTS       = 4,
  parameter int C_FRAME_CNT_WIDTH = 32,
  parameter int C_BYTE_CNT_WIDTH  = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [63:0]            current_time,
  input  logic                   time_running,
  input  logic                   enable,
  input  logic                   clear,
  input  logic [31:0]            sample_period,
  input  logic                   sample_req,
  input  logic [C_NUM_PORTS-1:0] mon_tvalid,
  input  logic [C_NUM_PORTS-1:0] mon_tready,
  input  logic [C_NUM_PORTS-1:0] mon_tlast,
  input  logic [C_NUM_PORTS-1:0] mon_tuser,
  output logic [LOG_WORD_W-1:0]  m_axis_log_tdata,
  output logic                   m_axis_log_tlast,
  output logic                   m_axis_log_tvalid,
  input  logic                   m_axis_log_tready,
  output logic                   busy,
  output logic                   snapshot_dropped
);

  localparam int NUM_WORDS = words_per_packet(C_NUM_PORTS);
  localparam int IDX_W     = $clog2(NUM_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  // ---------------------------------------------------------------------
  // Per-port counters
  // ---------------------------------------------------------------------
  logic [C_NUM_PORTS-1:0]       beat;
  logic [C_BYTE_CNT_WIDTH-1:0]  bytes_w  [C_NUM_PORTS];
  logic [C_FRAME_CNT_WIDTH-1:0] frames_w [C_NUM_PORTS];
  logic [C_FRAME_CNT_WIDTH-1:0] bad_w    [C_NUM_PORTS];

  assign beat = mon_tvalid & mon_tready & {C_NUM_PORTS{enable}};

  for (genvar g = 0; g < C_NUM_PORTS; g++) begin : g_port
    eth_stats_port_counter #(
      .C_FRAME_CNT_WIDTH (C_FRAME_CNT_WIDTH),
      .C_BYTE_CNT_WIDTH  (C_BYTE_CNT_WIDTH)
    ) u_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear_i  (clear),
      .beat_i   (beat[g]),
      .last_i   (mon_tlast[g]),
      .user_i   (mon_tuser[g]),
      .bytes_o  (bytes_w[g]),
      .frames_o (frames_w[g]),
      .bad_o    (bad_w[g])
    );
  end

  // ---------------------------------------------------------------------
  // Periodic snapshot timer
  // ---------------------------------------------------------------------
  logic [31:0] period_cnt_q, period_cnt_d;
  logic [31:0] period_last_q;
  logic        period_run;
  logic        period_change;
  logic        period_hit;
  logic        period_req;

  assign period_change = (sample_period != period_last_q);
  assign period_run    = enable & time_running & (sample_period != 32'd0);
  assign period_hit    = (period_cnt_q == (sample_period - 32'd1));
  assign period_req    = period_run & period_hit & ~period_change & ~clear;

  // Timer restarts on a period change or clear, otherwise counts while running
  always_comb begin
    period_cnt_d = period_cnt_q;
    if (clear || period_change) begin
      period_cnt_d = '0;
    end else if (period_run) begin
      period_cnt_d = period_hit ? 32'd0 : period_cnt_q + 32'd1;
    end
  end

  // Timer registers, including the last seen period for change detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt_q  <= '0;
      period_last_q <= '0;
    end else begin
      period_cnt_q  <= period_cnt_d;
      period_last_q <= sample_period;
    end
  end

  // ---------------------------------------------------------------------
  // Snapshot / log FSM
  // ---------------------------------------------------------------------
  logic             snap_req;
  log_state_t       state_q, state_d;
  logic [IDX_W-1:0] word_idx_q, word_idx_d;
  logic             capture;
  logic             drop_q, drop_d;

  assign snap_req = sample_req | period_req;

  // Packet sequencing: capture on request in IDLE, step words on handshake
  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    capture    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (snap_req) begin
          state_d    = ST_SEND;
          word_idx_d = '0;
          capture    = 1'b1;
        end
      end
      ST_SEND: begin
        if (m_axis_log_tready) begin
          if (word_idx_q == LAST_IDX) begin
            state_d    = ST_IDLE;
            word_idx_d = '0;
          end else begin
            word_idx_d = word_idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        word_idx_d = '0;
      end
    endcase
    drop_d = snap_req & (state_q == ST_SEND);
  end

  // FSM and drop-pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      word_idx_q <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      drop_q     <= drop_d;
    end
  end

  // ---------------------------------------------------------------------
  // Shadow registers frozen for the duration of a packet
  // ---------------------------------------------------------------------
  logic [63:0]                  time_sh_q;
  logic [C_BYTE_CNT_WIDTH-1:0]  bytes_sh_q  [C_NUM_PORTS];
  logic [C_FRAME_CNT_WIDTH-1:0] frames_sh_q [C_NUM_PORTS];
  logic [C_FRAME_CNT_WIDTH-1:0] bad_sh_q    [C_NUM_PORTS];

  // Capture registered counter values, so same-cycle beats and clear are not seen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      time_sh_q <= '0;
      for (int p = 0; p < C_NUM_PORTS; p++) begin
        bytes_sh_q[p]  <= '0;
        frames_sh_q[p] <= '0;
        bad_sh_q[p]    <= '0;
      end
    end else if (capture) begin
      time_sh_q <= current_time;
      for (int p = 0; p < C_NUM_PORTS; p++) begin
        bytes_sh_q[p]  <= bytes_w[p];
        frames_sh_q[p] <= frames_w[p];
        bad_sh_q[p]    <= bad_w[p];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output word selection
  // ---------------------------------------------------------------------
  logic [IDX_W-1:0]      word_sel;
  logic [LOG_WORD_W-1:0] log_word;

  assign word_sel = word_idx_q - 1'b1;

  // Word 0 is the timestamp; then bytes and {frames,bad} for each port in turn
  always_comb begin
    log_word = '0;
    if (word_idx_q == '0) begin
      log_word = time_sh_q;
    end else begin
      for (int p = 0; p < C_NUM_PORTS; p++) begin
        if ((word_sel >> 1) == IDX_W'(p)) begin
          if (word_sel[0]) begin
            log_word = {32'(frames_sh_q[p]), 32'(bad_sh_q[p])};
          end else begin
            log_word = 64'(bytes_sh_q[p]);
          end
        end
      end
    end
  end

  assign busy              = (state_q == ST_SEND);
  assign m_axis_log_tvalid = busy;
  assign m_axis_log_tdata  = busy ? log_word : '0;
  assign m_axis_log_tlast  = busy & (word_idx_q == LAST_IDX);
  assign snapshot_dropped  = drop_q;

endmodule

// File: tb/tb_eth_stats_collector_mc.sv
// Testbench for eth_stats_collector_mc: directed scenarios followed by
// randomized traffic, checked against a behavioural model through a
// queue of expected log words.
module tb_eth_stats_collector_mc;

  localparam int NP  = 2;
  localparam int FCW = 8;
  localparam int BCW = 16;
  localparam int WORDS = 1 + 2 * NP;

  typedef struct {
    logic [63:0] data;
    bit          last;
  } expWord_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [63:0]   curTime;
  logic          timeRunning;
  logic          enable;
  logic          clear;
  logic [31:0]   samplePeriod;
  logic          sampleReq;
  logic [NP-1:0] monValid;
  logic [NP-1:0] monReady;
  logic [NP-1:0] monLast;
  logic [NP-1:0] monUser;
  logic [63:0]   logData;
  logic          logLast;
  logic          logValid;
  logic          logReady;
  logic          busyO;
  logic          droppedO;

  int checks = 0;
  int errors = 0;
  int dutDrops = 0;

  expWord_t expQ[$];

  // model state
  longint unsigned mBytes  [NP];
  longint unsigned mFrames [NP];
  longint unsigned mBad    [NP];
  int unsigned     mPeriodCnt;
  logic [31:0]     mPrevPeriod;
  bit              mInFlight;
  int              mRemaining;
  bit              mExpDrop;
  int              mExpDropTotal;
  bit              mPreq;
  bit              mReq;
  expWord_t        mWord;

  always #5 clk = ~clk;

  eth_stats_collector_mc #(
    .C_NUM_PORTS       (NP),
    .C_FRAME_CNT_WIDTH (FCW),
    .C_BYTE_CNT_WIDTH  (BCW)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .current_time      (curTime),
    .time_running      (timeRunning),
    .enable            (enable),
    .clear             (clear),
    .sample_period     (samplePeriod),
    .sample_req        (sampleReq),
    .mon_tvalid        (monValid),
    .mon_tready        (monReady),
    .mon_tlast         (monLast),
    .mon_tuser         (monUser),
    .m_axis_log_tdata  (logData),
    .m_axis_log_tlast  (logLast),
    .m_axis_log_tvalid (logValid),
    .m_axis_log_tready (logReady),
    .busy              (busyO),
    .snapshot_dropped  (droppedO)
  );

  // One comparison: count it, report a mismatch
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Counter increment by the wrap/saturate rule for a given width
  function automatic longint unsigned bump(input longint unsigned v, input int w);
    longint unsigned maxV;
    maxV = (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
`ifdef ETH_STATS_SATURATE_EN
    return (v == maxV) ? v : v + 1;
`else
    return (v == maxV) ? 64'd0 : v + 1;
`endif
  endfunction

  // Reference model: snapshot requests, packet occupancy and counters
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NP; p++) begin
        mBytes[p] = 0; mFrames[p] = 0; mBad[p] = 0;
      end
      mPeriodCnt = 0;
      mPrevPeriod = 0;
      mInFlight = 0;
      mRemaining = 0;
      mExpDrop = 0;
      expQ.delete();
    end else begin
      mPreq = 0;
      if (clear || samplePeriod != mPrevPeriod) begin
        mPeriodCnt = 0;
      end else if (enable && timeRunning && samplePeriod != 0) begin
        if (mPeriodCnt == samplePeriod - 1) begin
          mPreq = 1;
          mPeriodCnt = 0;
        end else begin
          mPeriodCnt++;
        end
      end
      mPrevPeriod = samplePeriod;
      mReq = sampleReq || mPreq;
      mExpDrop = mReq && mInFlight;
      if (mExpDrop) mExpDropTotal++;
      if (mInFlight) begin
        if (logReady) begin
          mRemaining--;
          if (mRemaining == 0) mInFlight = 0;
        end
      end else if (mReq) begin
        mWord.data = curTime; mWord.last = 0;
        expQ.push_back(mWord);
        for (int p = 0; p < NP; p++) begin
          mWord.data = 64'(mBytes[p]); mWord.last = 0;
          expQ.push_back(mWord);
          mWord.data = (mFrames[p] << 32) | mBad[p]; mWord.last = (p == NP - 1);
          expQ.push_back(mWord);
        end
        mInFlight = 1;
        mRemaining = WORDS;
      end
      for (int p = 0; p < NP; p++) begin
        if (clear) begin
          mBytes[p] = 0; mFrames[p] = 0; mBad[p] = 0;
        end else if (enable && monValid[p] && monReady[p]) begin
          mBytes[p] = bump(mBytes[p], BCW);
          if (monLast[p]) begin
            mFrames[p] = bump(mFrames[p], FCW);
            if (monUser[p]) mBad[p] = bump(mBad[p], FCW);
          end
        end
      end
    end
  end

  // Monitor: compare status every cycle and log words as they are presented
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("busy", busyO, mInFlight);
      checkOutput("tvalid", logValid, mInFlight);
      checkOutput("dropped", droppedO, mExpDrop);
      if (droppedO) dutDrops++;
      if (logValid) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_word: got 0x%0h expected no word at %0t", logData, $time);
        end else begin
          checkOutput("tdata", logData, expQ[0].data);
          checkOutput("tlast", logLast, expQ[0].last);
          if (logReady) void'(expQ.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    curTime = curTime + 1;
  endtask

  // Drive one beat on a port for one cycle
  task automatic applyStimulus(input int port, input bit last, input bit user);
    monValid = '0; monLast = '0; monUser = '0;
    monValid[port] = 1'b1;
    monLast[port]  = last;
    monUser[port]  = user;
    tick();
    monValid = '0; monLast = '0; monUser = '0;
  endtask

  task automatic pulseSampleReq();
    sampleReq = 1'b1;
    tick();
    sampleReq = 1'b0;
  endtask

  // Wait for the model and DUT to drain, bounded
  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while ((busyO || mInFlight || expQ.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d cycles expected < %0d", n, budget);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_tvalid"}, logValid, 0);
    checkOutput({tag, "_tlast"}, logLast, 0);
    checkOutput({tag, "_tdata"}, logData, 0);
    checkOutput({tag, "_busy"}, busyO, 0);
    checkOutput({tag, "_dropped"}, droppedO, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int dropsBefore;
    mExpDropTotal = 0;
    rst_n = 1'b0;
    curTime = {$urandom, $urandom};
    timeRunning = 1'b0;
    enable = 1'b0;
    clear = 1'b0;
    samplePeriod = '0;
    sampleReq = 1'b0;
    monValid = '0; monReady = '1; monLast = '0; monUser = '0;
    logReady = 1'b1;
    #1;
    checkResetOutputs("reset");
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Three 64-beat frames on port 0, second one bad, then a snapshot
    enable = 1'b1;
    for (int f = 0; f < 3; f++)
      for (int b = 0; b < 64; b++)
        applyStimulus(0, b == 63, f == 1);
    pulseSampleReq();
    waitIdle(50);

    // Clear, tlast beat and sample request all in one cycle
    monValid[0] = 1'b1; monLast[0] = 1'b1;
    clear = 1'b1; sampleReq = 1'b1;
    tick();
    monValid = '0; monLast = '0; clear = 1'b0; sampleReq = 1'b0;
    waitIdle(50);
    pulseSampleReq();
    waitIdle(50);

    // Back-pressure mid-packet with a request that must be dropped
    applyStimulus(1, 1'b1, 1'b0);
    logReady = 1'b0;
    pulseSampleReq();
    tick();
    logReady = 1'b1;
    repeat (2) tick();
    logReady = 1'b0;
    repeat (4) tick();
    dropsBefore = dutDrops;
    pulseSampleReq();
    repeat (5) tick();
    checkOutput("stall_drop_count", dutDrops - dropsBefore, 1);
    logReady = 1'b1;
    waitIdle(50);

    // Periodic snapshots with an always-ready sink
    dropsBefore = dutDrops;
    samplePeriod = 32'd100;
    timeRunning = 1'b1;
    repeat (450) tick();
    checkOutput("period_drops", dutDrops - dropsBefore, 0);
    samplePeriod = '0;
    waitIdle(50);

    // 260 single-beat frames on port 1 to exercise the 8-bit frame counter
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int f = 0; f < 260; f++) applyStimulus(1, 1'b1, f[0]);
    pulseSampleReq();
    waitIdle(50);

    // Reset while word 2 is on the bus
    logReady = 1'b0;
    pulseSampleReq();
    logReady = 1'b1;
    repeat (2) tick();
    logReady = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midreset");
    repeat (2) tick();
    rst_n = 1'b1;
    logReady = 1'b1;
    tick();
    pulseSampleReq();
    waitIdle(50);

    // Randomized traffic
    samplePeriod = 32'd17;
    for (int i = 0; i < 3000; i++) begin
      enable      = ($urandom % 8) != 0;
      timeRunning = ($urandom % 10) != 0;
      monValid    = NP'($urandom);
      monReady    = NP'($urandom | $urandom);
      monLast     = NP'($urandom & $urandom & $urandom);
      monUser     = NP'($urandom & $urandom);
      clear       = ($urandom % 200) == 0;
      sampleReq   = ($urandom % 40) == 0;
      logReady    = ($urandom % 4) != 0;
      if (($urandom % 300) == 0) samplePeriod = $urandom_range(0, 40);
      tick();
    end
    monValid = '0; monLast = '0; monUser = '0;
    clear = 1'b0; sampleReq = 1'b0; samplePeriod = '0;
    logReady = 1'b1;
    waitIdle(100);
    checkOutput("queue_empty", expQ.size(), 0);
    checkOutput("drop_total", dutDrops, mExpDropTotal);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
